sa_seq_ctrl: RTL and testbench
==============================

# sa_seq_ctrl

Sequencer that accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake and adds them bit-serially, LSB first, through a one-bit full-adder/carry slice. It collects the WIDTH+1-bit result and returns it over a second valid/ready handshake. This lets parallel-word logic use the serial adder without hand-timed per-bit stimulus or a manual reset pulse between operations.

## Interface
- WIDTH, 4: operand width in bits, 2..32.
- CW, $clog2(WIDTH+1): bit-counter width (localparam, not overridable).
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; clears all state.
- in_valid  in  1  operand request.
- in_ready  out  1  high only in IDLE.
- a_in  in  WIDTH  operand A.
- b_in  in  WIDTH  operand B.
- cin_in  in  1  carry-in, used on bit 0 only.
- abort  in  1  synchronous cancel, returns to IDLE next edge.
- res_valid  out  1  result available (DONE state).
- res_ready  in  1  consumer accepts result.
- result  out  WIDTH+1  {final carry, sum}; held stable while res_valid.
- busy  out  1  high in SHIFT.

## Operation
- States: IDLE, SHIFT, DONE (2-bit encoding, IDLE = 0).
- **IDLE:** in_ready = 1.
  - On in_valid & in_ready & !abort: a_sh <= a_in, b_sh <= b_in, carry <= cin_in, cnt <= 0, sum_sh <= 0, go to SHIFT.
- **SHIFT:** each cycle:
  - s = a_sh[0] ^ b_sh[0] ^ carry.
  - carry <= majority(a_sh[0], b_sh[0], carry).
  - a_sh and b_sh shift right.
  - sum_sh <= {s, sum_sh[WIDTH-1:1]}.
  - cnt++.
  - When cnt == WIDTH-1, after this bit: result <= {carry_next, sum_next}, go to DONE.
- **DONE:** res_valid = 1. On res_ready, go to IDLE. A new operand is never accepted in the same cycle as a result handoff.
- **abort:** in SHIFT or DONE, go to IDLE next edge. result and res_valid are cleared and the partial sum is discarded. abort in IDLE blocks acceptance; abort wins over in_valid.
- **Arithmetic:** unsigned, modulo 2^(WIDTH+1); result[WIDTH] is the carry-out. No overflow flag.
- in_valid while not in_ready is ignored. Operands are sampled only at acceptance, so later changes on a_in/b_in have no effect.

## Timing
- **Reset values:**
  - state = IDLE, so in_ready = 1 during and after reset.
  - res_valid = 0, busy = 0, result = 0, cnt = 0, carry = 0.
- **Acceptance edge T0:** SHIFT occupies edges T1..TWIDTH. res_valid rises after edge TWIDTH, so the result is visible WIDTH cycles after the accepting edge.
- **Minimum op period:** WIDTH+2 cycles (accept, WIDTH shifts, one DONE cycle with res_ready=1).
- **Back-pressure:** with res_ready=0, DONE holds indefinitely and result is stable.
- **Reset mid-SHIFT or mid-DONE:** immediate return to reset values. No result is emitted.
- in_ready, res_valid and busy are decoded from registered state only, with no combinational path from inputs.

## Structure
- Package sa_pkg:
  - state enum (IDLE, SHIFT, DONE).
  - default WIDTH constant.
- Sub-module sa_bit_slice:
  - Combinational full adder plus carry flip-flop.
  - Ports: clk, reset, load, cin_load, a, b, s, cout.
  - load forces carry <= cin_load.
  - The controller instantiates exactly one.
- Controller contains the FSM, the operand/sum shift registers, the counter and the result register.

## Test plan
- **WIDTH=4, basic:** a=1111, b=1101, cin=1 -> result=11101 after 4 shift cycles; busy high for exactly 4 cycles.
- **WIDTH=5, basic:** a=11011, b=10001, cin=1 -> result=101101; with cin=0 -> 101100.
- **WIDTH=4, back-pressure:** a=1111, b=0001, cin=0 -> result=10000. Hold res_ready=0 for 5 cycles: res_valid and result stable. Then res_ready=1: IDLE next edge.
- **Back-to-back:** in_valid held high with two queued operand pairs -> second accepted only after first result handoff. Period is WIDTH+2 cycles.
- **Abort in SHIFT:** assert abort at bit 2 -> IDLE next edge, res_valid never rises. A following op 0101+0011 cin=0 gives 01000, with no stale carry.
- **Reset mid-SHIFT:** async reset between edges -> outputs at reset values immediately. Check again for reset asserted in DONE.

Source files
------------

// File: rtl/sa_pkg.sv
// Shared types and constants for the bit-serial adder sequencer.
package sa_pkg;

    localparam int unsigned DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StShift = 2'd1,
        StDone  = 2'd2
    } sa_state_e;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/sa_seq_ctrl_if.sv
// Operand request and result return handshakes of the serial adder sequencer.
interface sa_seq_ctrl_if
    import sa_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a_in;
    logic [WIDTH-1:0] b_in;
    logic             cin_in;
    logic             abort;
    logic             res_valid;
    logic             res_ready;
    logic [WIDTH:0]   result;
    logic             busy;

    modport master (
        output in_valid, a_in, b_in, cin_in, abort, res_ready,
        input  in_ready, res_valid, result, busy
    );

    modport slave (
        input  in_valid, a_in, b_in, cin_in, abort, res_ready,
        output in_ready, res_valid, result, busy
    );

endinterface

// File: rtl/sa_bit_slice.sv
// One-bit full adder with a registered carry; load seeds the carry for a new operation.
module sa_bit_slice
    import sa_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic load,
    input  logic cin_load,
    input  logic a,
    input  logic b,
    output logic s,
    output logic cout
);

    logic carry_q;

    assign s    = a ^ b ^ carry_q;
    assign cout = maj3(a, b, carry_q);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else if (load) begin
            carry_q <= cin_load;
        end else begin
            carry_q <= cout;
        end
    end

endmodule

// File: rtl/sa_seq_ctrl.sv
// Sequences a WIDTH-bit add through one serial slice, LSB first, and returns {carry, sum}.
module sa_seq_ctrl
    import sa_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH
) (
    input  logic          clk,
    input  logic          reset,
    sa_seq_ctrl_if.slave  bus
);

    localparam int unsigned CW = $clog2(WIDTH + 1);
    localparam logic [CW-1:0] LastBit = CW'(WIDTH - 1);

    sa_state_e        state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH:0]   result_q, result_d;

    logic load;
    logic slice_a, slice_b, slice_s, slice_cout;

    // Operand bits are gated outside SHIFT so the slice carry drains to zero while idle.
    assign slice_a = (state_q == StShift) & a_sh_q[0];
    assign slice_b = (state_q == StShift) & b_sh_q[0];

    sa_bit_slice u_slice (
        .clk      (clk),
        .reset    (reset),
        .load     (load),
        .cin_load (bus.cin_in),
        .a        (slice_a),
        .b        (slice_b),
        .s        (slice_s),
        .cout     (slice_cout)
    );

    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        cnt_d    = cnt_q;
        result_d = result_q;
        load     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (bus.in_valid && !bus.abort) begin
                    load     = 1'b1;
                    a_sh_d   = bus.a_in;
                    b_sh_d   = bus.b_in;
                    sum_sh_d = '0;
                    cnt_d    = '0;
                    state_d  = StShift;
                end
            end
            StShift: begin
                if (bus.abort) begin
                    sum_sh_d = '0;
                    result_d = '0;
                    state_d  = StIdle;
                end else begin
                    a_sh_d   = a_sh_q >> 1;
                    b_sh_d   = b_sh_q >> 1;
                    sum_sh_d = {slice_s, sum_sh_q[WIDTH-1:1]};
                    cnt_d    = cnt_q + CW'(1);
                    if (cnt_q == LastBit) begin
                        result_d = {slice_cout, sum_sh_d};
                        state_d  = StDone;
                    end
                end
            end
            StDone: begin
                if (bus.abort) begin
                    result_d = '0;
                    state_d  = StIdle;
                end else if (bus.res_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            cnt_q    <= cnt_d;
            result_q <= result_d;
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.busy      = (state_q == StShift);
    assign bus.res_valid = (state_q == StDone);
    assign bus.result    = result_q;

endmodule

// File: tb/tb_sa_seq_ctrl.sv
// Directed bench for sa_seq_ctrl at WIDTH=4 and WIDTH=5 with hand-computed sums.
module tb_sa_seq_ctrl;

    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sa_seq_ctrl_if #(.WIDTH(4)) if4 ();
    sa_seq_ctrl_if #(.WIDTH(5)) if5 ();

    sa_seq_ctrl #(.WIDTH(4)) dut4 (.clk(clk), .reset(reset), .bus(if4));
    sa_seq_ctrl #(.WIDTH(5)) dut5 (.clk(clk), .reset(reset), .bus(if5));

    task automatic accept4(input logic [3:0] a, input logic [3:0] b, input logic cin);
        if4.a_in = a; if4.b_in = b; if4.cin_in = cin; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
    endtask

    task automatic accept5(input logic [4:0] a, input logic [4:0] b, input logic cin);
        if5.a_in = a; if5.b_in = b; if5.cin_in = cin; if5.in_valid = 1'b1;
        @(posedge clk); #1;
        if5.in_valid = 1'b0;
    endtask

    // Cycles from the current sample point until res_valid (bounded at 50).
    task automatic wait4(output int n, output int busy_n);
        n = 0; busy_n = 0;
        while (!if4.res_valid && n < 50) begin
            if (if4.busy) busy_n++;
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic wait5(output int n);
        n = 0;
        while (!if5.res_valid && n < 50) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3 reset = 1'b1;
        #1;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy} !== 3'b100) begin
            errors++;
            $display("FAIL reset_status: got %b want 100", {if4.in_ready, if4.res_valid, if4.busy});
        end
        vectors++;
        if (if4.result !== 5'b00000) begin
            errors++;
            $display("FAIL reset_result: got %b want 00000", if4.result);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy, if5.in_ready} !== 4'b1001) begin
            errors++;
            $display("FAIL post_reset_status: got %b want 1001",
                     {if4.in_ready, if4.res_valid, if4.busy, if5.in_ready});
        end
    endtask

    task automatic test_basic4();
        int n, bn;
        accept4(4'b1111, 4'b1101, 1'b1);
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy} !== 3'b001) begin
            errors++;
            $display("FAIL basic4_accept: got %b want 001", {if4.in_ready, if4.res_valid, if4.busy});
        end
        wait4(n, bn);
        vectors++;
        if (n !== 4) begin
            errors++;
            $display("FAIL basic4_latency: got %0d want 4", n);
        end
        vectors++;
        if (bn !== 4) begin
            errors++;
            $display("FAIL basic4_busy_cycles: got %0d want 4", bn);
        end
        vectors++;
        if (if4.result !== 5'b11101) begin
            errors++;
            $display("FAIL basic4_result: got %b want 11101", if4.result);
        end
        if4.res_ready = 1'b1;
        @(posedge clk); #1;
        if4.res_ready = 1'b0;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy} !== 3'b100) begin
            errors++;
            $display("FAIL basic4_handoff: got %b want 100", {if4.in_ready, if4.res_valid, if4.busy});
        end
    endtask

    task automatic test_basic5();
        int n;
        logic [5:0] exp_res;
        for (int i = 0; i < 2; i++) begin
            exp_res = (i == 0) ? 6'b101101 : 6'b101100;
            accept5(5'b11011, 5'b10001, (i == 0));
            wait5(n);
            vectors++;
            if (n !== 5) begin
                errors++;
                $display("FAIL basic5_latency[%0d]: got %0d want 5", i, n);
            end
            vectors++;
            if (if5.result !== exp_res) begin
                errors++;
                $display("FAIL basic5_result[%0d]: got %b want %b", i, if5.result, exp_res);
            end
            if5.res_ready = 1'b1;
            @(posedge clk); #1;
            if5.res_ready = 1'b0;
        end
    endtask

    task automatic test_backpressure();
        int n, bn;
        accept4(4'b1111, 4'b0001, 1'b0);
        wait4(n, bn);
        vectors++;
        if (if4.result !== 5'b10000) begin
            errors++;
            $display("FAIL bp_result: got %b want 10000", if4.result);
        end
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            vectors++;
            if ({if4.res_valid, if4.result} !== 6'b110000) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got %b want 110000", i, {if4.res_valid, if4.result});
            end
        end
        if4.res_ready = 1'b1;
        @(posedge clk); #1;
        if4.res_ready = 1'b0;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy} !== 3'b100) begin
            errors++;
            $display("FAIL bp_release: got %b want 100", {if4.in_ready, if4.res_valid, if4.busy});
        end
    endtask

    task automatic test_back_to_back();
        int n, bn, t0;
        if4.a_in = 4'b0011; if4.b_in = 4'b0100; if4.cin_in = 1'b0;
        if4.res_ready = 1'b1; if4.in_valid = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        // Second pair queued right away; the first op must keep its sampled operands.
        if4.a_in = 4'b1001; if4.b_in = 4'b1010; if4.cin_in = 1'b1;
        wait4(n, bn);
        vectors++;
        if (if4.result !== 5'b00111) begin
            errors++;
            $display("FAIL b2b_first_result: got %b want 00111", if4.result);
        end
        @(posedge clk); #1;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy} !== 3'b100) begin
            errors++;
            $display("FAIL b2b_handoff_no_accept: got %b want 100",
                     {if4.in_ready, if4.res_valid, if4.busy});
        end
        @(posedge clk); #1;
        if4.in_valid = 1'b0;
        vectors++;
        if (!(if4.busy === 1'b1 && (cyc - t0) == 6)) begin
            errors++;
            $display("FAIL b2b_period: got busy=%b period=%0d want busy=1 period=6",
                     if4.busy, cyc - t0);
        end
        wait4(n, bn);
        vectors++;
        if (if4.result !== 5'b10100) begin
            errors++;
            $display("FAIL b2b_second_result: got %b want 10100", if4.result);
        end
        @(posedge clk); #1;
        if4.res_ready = 1'b0;
    endtask

    task automatic test_abort();
        int n, bn;
        logic seen;
        accept4(4'b1111, 4'b1111, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        if4.abort = 1'b1;
        @(posedge clk); #1;
        if4.abort = 1'b0;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy, if4.result} !== 8'b100_00000) begin
            errors++;
            $display("FAIL abort_shift: got %b want 10000000",
                     {if4.in_ready, if4.res_valid, if4.busy, if4.result});
        end
        seen = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
            seen |= if4.res_valid;
        end
        vectors++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_result: got res_valid seen=%b want 0", seen);
        end
        accept4(4'b0101, 4'b0011, 1'b0);
        wait4(n, bn);
        vectors++;
        if (if4.result !== 5'b01000) begin
            errors++;
            $display("FAIL abort_next_result: got %b want 01000", if4.result);
        end
        if4.res_ready = 1'b1;
        @(posedge clk); #1;
        if4.res_ready = 1'b0;
        if4.in_valid = 1'b1; if4.abort = 1'b1;
        @(posedge clk); #1;
        if4.in_valid = 1'b0; if4.abort = 1'b0;
        vectors++;
        if ({if4.in_ready, if4.busy} !== 2'b10) begin
            errors++;
            $display("FAIL abort_idle_blocks: got %b want 10", {if4.in_ready, if4.busy});
        end
    endtask

    task automatic test_reset_mid();
        int n, bn;
        accept4(4'b1011, 4'b0110, 1'b1);
        repeat (2) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy, if4.result} !== 8'b100_00000) begin
            errors++;
            $display("FAIL reset_mid_shift: got %b want 10000000",
                     {if4.in_ready, if4.res_valid, if4.busy, if4.result});
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
        accept4(4'b0111, 4'b0001, 1'b0);
        wait4(n, bn);
        vectors++;
        if (if4.result !== 5'b01000) begin
            errors++;
            $display("FAIL reset_recover_result: got %b want 01000", if4.result);
        end
        #2 reset = 1'b1;
        #1;
        vectors++;
        if ({if4.in_ready, if4.res_valid, if4.busy, if4.result} !== 8'b100_00000) begin
            errors++;
            $display("FAIL reset_mid_done: got %b want 10000000",
                     {if4.in_ready, if4.res_valid, if4.busy, if4.result});
        end
        @(negedge clk) reset = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        if4.in_valid = 1'b0; if4.a_in = '0; if4.b_in = '0; if4.cin_in = 1'b0;
        if4.abort = 1'b0; if4.res_ready = 1'b0;
        if5.in_valid = 1'b0; if5.a_in = '0; if5.b_in = '0; if5.cin_in = 1'b0;
        if5.abort = 1'b0; if5.res_ready = 1'b0;
        test_reset();
        test_basic4();
        test_basic5();
        test_backpressure();
        test_back_to_back();
        test_abort();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
        $fatal(1);
    end

endmodule
